// File: rtl/irq_prio_pkg.sv
// Shared types for the interrupt priority controller.
// FSM state encoding and arbitration mode constants.
package irq_prio_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic logic mode_of(int rr);
    return (rr != 0) ? MODE_RR : MODE_FIXED;
  endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational arbiter: rotated search over a doubled request vector.
// Fixed mode forces the base to 0 and scans from the top index down.
module irq_prio_arb
  import irq_prio_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  input  logic              mode_i,
  output logic              gnt_any_o,
  output logic [CH_W-1:0]   gnt_idx_o
);

  logic [2*NUM_CH-1:0] dbl;
  logic [CH_W-1:0]     base;
  logic                hit;

  assign dbl  = {req_i, req_i};
  assign base = (mode_i == MODE_RR) ? ptr_i : '0;

  function automatic int slot(logic rr, int b, int k);
    return rr ? (b + k) : (NUM_CH - 1 - k);
  endfunction

  function automatic int wrap(int j);
    return (j >= NUM_CH) ? (j - NUM_CH) : j;
  endfunction

  always_comb begin
    gnt_any_o = |req_i;
    gnt_idx_o = '0;
    hit       = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!hit && dbl[slot(mode_i, int'(base), k)]) begin
        hit       = 1'b1;
        gnt_idx_o = CH_W'(wrap(slot(mode_i, int'(base), k)));
      end
    end
  end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt capture, masking and one-at-a-time grant presentation
// on a registered valid/ready port.
module irq_prio_ctrl
  import irq_prio_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int DATA_W  = 8,
  parameter  int RR_MODE = 0,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] irq_i,
  input  logic [DATA_W-1:0] data_i [NUM_CH],
  input  logic [NUM_CH-1:0] mask_i,
  output logic              valid_o,
  output logic [CH_W-1:0]   ch_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i,
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] overrun_o
);

  localparam logic MODE = mode_of(RR_MODE);

  state_e            state_q;
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] pending_d;
  logic [NUM_CH-1:0] overrun_q;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] clr;
  logic [DATA_W-1:0] payload_q [NUM_CH];
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ptr_d;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              grant;
  logic              valid_q;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] data_q;

  assign elig = pending_q & ~mask_i;

  irq_prio_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i     (elig),
    .ptr_i     (ptr_q),
    .mode_i    (MODE),
    .gnt_any_o (gnt_any),
    .gnt_idx_o (gnt_idx)
  );

  assign grant = (state_q == IDLE) && gnt_any;

  always_comb begin
    clr = '0;
    if (grant) clr[gnt_idx] = 1'b1;
  end

  // A same-cycle request re-arms the bit the grant is clearing.
  assign pending_d = irq_i | (pending_q & ~clr);
  assign ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      overrun_q <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      data_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) payload_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= irq_i & pending_q & ~clr;
      for (int i = 0; i < NUM_CH; i++) begin
        if (irq_i[i]) payload_q[i] <= data_i[i];
      end
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            ch_q    <= gnt_idx;
            data_q  <= payload_q[gnt_idx];
            valid_q <= 1'b1;
            state_q <= PRESENT;
            if (MODE == MODE_RR) ptr_q <= ptr_d;
          end
        end
        PRESENT: begin
          if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign valid_o   = valid_q;
  assign ch_o      = ch_q;
  assign data_o    = data_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;

endmodule
